serial_byte_rx: RTL and testbench

//  Deserialiser stage directly downstream of the single-bit registered serial link.
//  - Samples the serial bit stream while chip-select is high.
//  - Assembles WIDTH-bit words and queues them in a small FIFO.
//  - Presents words to the core through a valid/ready handshake.
//  - Flags lost words (overflow) and truncated frames (framing error).

---
 rtl/zube_pkg.sv | 19 +
 rtl/serial_byte_rx_if.sv | 24 ++
 rtl/zube_sync_fifo.sv | 69 ++++++
 rtl/serial_byte_rx.sv | 99 +++++++++
 tb/tb_serial_byte_rx.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zube_pkg.sv
// Shared constants and helpers for the serial receive path.
package zube_pkg;

    localparam int unsigned ZUBE_WORD_W   = 8;
    localparam int unsigned ZUBE_RX_DEPTH = 4;

    // Bits needed to encode values 0..value-1 (0 for value <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_byte_rx_if.sv
// Valid/ready word handshake between the deserialiser and the core.
interface serial_byte_rx_if
    import zube_pkg::*;
#(
    parameter int unsigned WIDTH = ZUBE_WORD_W
);

    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/zube_sync_fifo.sv
// Single-clock FIFO with registered storage; a push into a full FIFO is
// accepted when a pop happens on the same edge.
module zube_sync_fifo
    import zube_pkg::*;
#(
    parameter int unsigned WIDTH = ZUBE_WORD_W,
    parameter int unsigned DEPTH = ZUBE_RX_DEPTH,
    localparam int unsigned CW   = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [CW-1:0]    o_count,
    output logic             o_drop
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign w_do_pop  = i_pop & ~o_empty;
    // Slot freed by a same-edge pop makes room for the incoming word.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_drop    = i_push & ~w_do_push;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        r_count <= CW'(DEPTH));

endmodule

// File: rtl/serial_byte_rx.sv
// Serial-to-word receiver: shifts bits while cs is high, queues completed
// words in a FIFO and flags dropped words and truncated frames.
module serial_byte_rx
    import zube_pkg::*;
#(
    parameter int unsigned WIDTH     = ZUBE_WORD_W,
    parameter int unsigned DEPTH     = ZUBE_RX_DEPTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             data_in,
    serial_byte_rx_if.master rx,
    output logic             overflow,
    output logic             frame_err,
    input  logic             clear
);

    localparam int unsigned BW = clog2(WIDTH);
    localparam int unsigned CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bit_cnt;
    logic             r_overflow;
    logic             r_frame_err;
    logic [WIDTH-1:0] w_next_shift;
    logic [WIDTH-1:0] w_rx_data;
    logic             w_word_done;
    logic             w_frame_break;
    logic             w_drop;
    logic             w_empty;
    logic             w_full;
    logic [CW-1:0]    w_count;

    always_comb begin
        w_next_shift = r_shift;
        if (MSB_FIRST) begin
            w_next_shift = {r_shift[WIDTH-2:0], data_in};
        end else begin
            w_next_shift = {data_in, r_shift[WIDTH-1:1]};
        end
    end

    // The word is pushed on the edge that samples its last bit, so the
    // FIFO input is the shifted value, not the registered one.
    assign w_word_done   = cs & (r_bit_cnt == BW'(WIDTH - 1));
    assign w_frame_break = ~cs & (r_bit_cnt != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (cs) begin
            r_shift   <= w_next_shift;
            r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + BW'(1);
        end else if (w_frame_break) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overflow  <= w_drop | (r_overflow & ~clear);
            r_frame_err <= w_frame_break | (r_frame_err & ~clear);
        end
    end

    zube_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_word_done),
        .i_data  (w_next_shift),
        .i_pop   (rx.rx_ready),
        .o_data  (w_rx_data),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count),
        .o_drop  (w_drop)
    );

    assign rx.rx_data  = w_rx_data;
    assign rx.rx_valid = ~w_empty;
    assign overflow    = r_overflow;
    assign frame_err   = r_frame_err;

    a_full_count: assert property (@(posedge clk) disable iff (reset)
        w_full |-> (w_count == CW'(DEPTH)));
    a_empty_count: assert property (@(posedge clk) disable iff (reset)
        w_empty == (w_count == '0));

endmodule

// File: tb/tb_serial_byte_rx.sv
// Bench for serial_byte_rx: an MSB-first and an LSB-first instance share one
// serial stream and are compared against a queue-based reference model.
module tb_serial_byte_rx;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic reset, cs, data_in, rx_ready, clear;
    logic ovf_m, fe_m, ovf_l, fe_l;

    serial_byte_rx_if #(.WIDTH(W)) if_m ();
    serial_byte_rx_if #(.WIDTH(W)) if_l ();

    assign if_m.rx_ready = rx_ready;
    assign if_l.rx_ready = rx_ready;

    serial_byte_rx #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .cs(cs), .data_in(data_in), .rx(if_m),
        .overflow(ovf_m), .frame_err(fe_m), .clear(clear)
    );

    serial_byte_rx #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .cs(cs), .data_in(data_in), .rx(if_l),
        .overflow(ovf_l), .frame_err(fe_l), .clear(clear)
    );

    always #5 clk = ~clk;

    // Reference model: bits of the current frame, queued words as each
    // bit order would interpret them, and the two sticky flags.
    bit             mbits[$];
    logic [W-1:0]   q_m[$];
    logic [W-1:0]   q_l[$];
    bit             m_ovf, m_fe;
    int             n_checks = 0;
    int             n_fail   = 0;

    function automatic logic [W-1:0] head_m();
        return (q_m.size() != 0) ? q_m[0] : '0;
    endfunction

    function automatic logic [W-1:0] head_l();
        return (q_l.size() != 0) ? q_l[0] : '0;
    endfunction

    task automatic model_clear();
        mbits.delete();
        q_m.delete();
        q_l.delete();
        m_ovf = 1'b0;
        m_fe  = 1'b0;
    endtask

    task automatic step();
        bit           ovf_set, fe_set;
        logic [W-1:0] wm, wl;
        @(posedge clk);
        ovf_set = 1'b0;
        fe_set  = 1'b0;
        if (reset) begin
            model_clear();
        end else begin
            if (q_m.size() != 0 && rx_ready) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
            end
            if (cs) begin
                mbits.push_back(data_in);
                if (mbits.size() == W) begin
                    wm = '0;
                    wl = '0;
                    for (int i = 0; i < W; i++) begin
                        wm = wm | (W'(mbits[i]) << (W - 1 - i));
                        wl = wl | (W'(mbits[i]) << i);
                    end
                    mbits.delete();
                    if (q_m.size() < D) begin
                        q_m.push_back(wm);
                        q_l.push_back(wl);
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
            end else if (mbits.size() != 0) begin
                mbits.delete();
                fe_set = 1'b1;
            end
            m_ovf = ovf_set | (m_ovf & !clear);
            m_fe  = fe_set  | (m_fe  & !clear);
        end
        #1;
    endtask

    // Drives the first n bits of w, most significant bit first, with cs high.
    task automatic send_bits(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            cs      = 1'b1;
            data_in = w[W-1-i];
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cs = 1'b0; data_in = 1'b0; rx_ready = 1'b0; clear = 1'b0;
        model_clear();
        step();
        step();
        n_checks++;
        if ({if_m.rx_valid, if_m.rx_data, ovf_m, fe_m} !== '0) begin
            n_fail++;
            $display("FAIL reset_m: got v=%b d=%h o=%b f=%b expected all 0",
                     if_m.rx_valid, if_m.rx_data, ovf_m, fe_m);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if ({if_l.rx_valid, if_l.rx_data, ovf_l, fe_l} !== '0) begin
            n_fail++;
            $display("FAIL reset_l: got v=%b d=%h o=%b f=%b expected all 0",
                     if_l.rx_valid, if_l.rx_data, ovf_l, fe_l);
        end
    endtask

    task automatic test_single_word();
        logic [W-1:0] w;
        w = 8'hA5;
        send_bits(w, 7);
        n_checks++;
        if (if_m.rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: rx_valid=%b expected 0", if_m.rx_valid);
        end
        send_bits(w << 7, 1);
        cs = 1'b0;
        n_checks++;
        if (if_m.rx_valid !== 1'b1 || if_m.rx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_m: got v=%b d=%h expected v=1 d=a5", if_m.rx_valid, if_m.rx_data);
        end
        n_checks++;
        if (if_l.rx_valid !== 1'b1 || if_l.rx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_l: got v=%b d=%h expected v=1 d=a5", if_l.rx_valid, if_l.rx_data);
        end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        n_checks++;
        if (if_m.rx_valid !== 1'b0 || if_l.rx_valid !== 1'b0 || if_m.rx_data !== '0) begin
            n_fail++;
            $display("FAIL single_pop: got vm=%b vl=%b dm=%h expected 0 0 00",
                     if_m.rx_valid, if_l.rx_valid, if_m.rx_data);
        end
    endtask

    task automatic test_overflow();
        rx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_bits(W'(k), 8);
        cs = 1'b0;
        n_checks++;
        if (ovf_m !== 1'b1 || ovf_l !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: got m=%b l=%b expected 1 1", ovf_m, ovf_l);
        end
        rx_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (if_m.rx_valid !== 1'b1 || if_m.rx_data !== W'(k)) begin
                n_fail++;
                $display("FAIL drain_m%0d: got v=%b d=%h expected v=1 d=%h", k, if_m.rx_valid, if_m.rx_data, W'(k));
            end
            n_checks++;
            if (if_l.rx_data !== head_l()) begin
                n_fail++;
                $display("FAIL drain_l%0d: got %h expected %h", k, if_l.rx_data, head_l());
            end
            step();
        end
        rx_ready = 1'b0;
        n_checks++;
        if (if_m.rx_valid !== 1'b0 || ovf_m !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_end: got v=%b ovf=%b expected v=0 ovf=1", if_m.rx_valid, ovf_m);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++;
        if (ovf_m !== 1'b0 || ovf_l !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear: got m=%b l=%b expected 0 0", ovf_m, ovf_l);
        end
    endtask

    task automatic test_framing();
        send_bits(8'hE0, 3);
        cs = 1'b0;
        step();
        n_checks++;
        if (fe_m !== 1'b1 || fe_l !== 1'b1 || if_m.rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_set: got fm=%b fl=%b v=%b expected 1 1 0", fe_m, fe_l, if_m.rx_valid);
        end
        send_bits(8'h3C, 8);
        cs = 1'b0;
        n_checks++;
        if (if_m.rx_data !== 8'h3C || if_l.rx_data !== head_l()) begin
            n_fail++;
            $display("FAIL frame_recover: got m=%h l=%h expected %h %h", if_m.rx_data, if_l.rx_data, 8'h3C, head_l());
        end
        rx_ready = 1'b1; clear = 1'b1;
        step();
        rx_ready = 1'b0; clear = 1'b0;
        send_bits(8'hF0, 4);
        cs = 1'b0;
        step();
        send_bits(8'h96, 8);
        cs = 1'b0;
        n_checks++;
        if (fe_m !== 1'b1 || if_m.rx_data !== 8'h96 || if_m.rx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_glitch: got f=%b d=%h v=%b expected 1 96 1", fe_m, if_m.rx_data, if_m.rx_valid);
        end
        rx_ready = 1'b1; clear = 1'b1;
        step();
        rx_ready = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset_midword();
        rx_ready = 1'b0;
        send_bits(8'h12, 8);
        send_bits(8'h34, 8);
        send_bits(8'hFF, 5);
        #2;
        cs    = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({if_m.rx_valid, if_m.rx_data, ovf_m, fe_m, if_l.rx_valid, if_l.rx_data, ovf_l, fe_l} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got vm=%b dm=%h vl=%b dl=%h expected all 0",
                     if_m.rx_valid, if_m.rx_data, if_l.rx_valid, if_l.rx_data);
        end
        model_clear();
        step();
        reset = 1'b0;
        send_bits(8'h81, 8);
        cs = 1'b0;
        n_checks++;
        if (if_m.rx_data !== 8'h81 || if_l.rx_data !== 8'h81 || fe_m !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: got m=%h l=%h fe=%b expected 81 81 0", if_m.rx_data, if_l.rx_data, fe_m);
        end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

    task automatic test_full_simul();
        logic [W-1:0] exp_words [4];
        exp_words = '{8'h22, 8'h33, 8'h44, 8'h55};
        rx_ready = 1'b0;
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        send_bits(8'h33, 8);
        send_bits(8'h44, 8);
        send_bits(8'h55, 7);
        rx_ready = 1'b1;
        send_bits(8'h55 << 7, 1);
        rx_ready = 1'b0;
        cs = 1'b0;
        n_checks++;
        if (ovf_m !== 1'b0 || ovf_l !== 1'b0) begin
            n_fail++;
            $display("FAIL full_simul_ovf: got m=%b l=%b expected 0 0", ovf_m, ovf_l);
        end
        rx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (if_m.rx_valid !== 1'b1 || if_m.rx_data !== exp_words[k]) begin
                n_fail++;
                $display("FAIL full_simul_drain%0d: got v=%b d=%h expected v=1 d=%h",
                         k, if_m.rx_valid, if_m.rx_data, exp_words[k]);
            end
            step();
        end
        rx_ready = 1'b0;
        n_checks++;
        if (if_m.rx_valid !== 1'b0 || if_l.rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_simul_empty: got m=%b l=%b expected 0 0", if_m.rx_valid, if_l.rx_valid);
        end
    endtask

    task automatic test_clear_vs_set();
        send_bits(8'hA0, 3);
        cs = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++;
        if (fe_m !== 1'b1 || fe_l !== 1'b1) begin
            n_fail++;
            $display("FAIL fe_set_wins: got m=%b l=%b expected 1 1", fe_m, fe_l);
        end
        rx_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_bits(W'(8'hC0 + k), 8);
        send_bits(8'h7E, 7);
        clear = 1'b1;
        send_bits(8'h7E << 7, 1);
        clear = 1'b0;
        cs = 1'b0;
        n_checks++;
        if (ovf_m !== 1'b1 || ovf_l !== 1'b1 || fe_m !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_set_wins: got om=%b ol=%b fe=%b expected 1 1 0", ovf_m, ovf_l, fe_m);
        end
        rx_ready = 1'b1; clear = 1'b1;
        for (int k = 0; k < 4; k++) step();
        rx_ready = 1'b0; clear = 1'b0;
        n_checks++;
        if (ovf_m !== 1'b0 || if_m.rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_cleared: got o=%b v=%b expected 0 0", ovf_m, if_m.rx_valid);
        end
    endtask

    task automatic test_random();
        int unsigned mode;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            mode     = (cyc / 256) % 3;
            cs       = ($urandom_range(0, 15) != 0);
            data_in  = 1'($urandom);
            rx_ready = (mode == 0) ? ($urandom_range(0, 7) == 0) :
                       (mode == 1) ? ($urandom_range(0, 1) == 0) :
                                     ($urandom_range(0, 7) != 0);
            clear    = ($urandom_range(0, 40) == 0);
            reset    = ($urandom_range(0, 700) == 0);
            step();
            n_checks++;
            if (if_m.rx_valid !== (q_m.size() != 0) || if_m.rx_data !== head_m()) begin
                n_fail++;
                $display("FAIL rand_rx_m @%0d: got v=%b d=%h expected v=%b d=%h",
                         cyc, if_m.rx_valid, if_m.rx_data, q_m.size() != 0, head_m());
            end
            n_checks++;
            if (if_l.rx_valid !== (q_l.size() != 0) || if_l.rx_data !== head_l()) begin
                n_fail++;
                $display("FAIL rand_rx_l @%0d: got v=%b d=%h expected v=%b d=%h",
                         cyc, if_l.rx_valid, if_l.rx_data, q_l.size() != 0, head_l());
            end
            n_checks++;
            if (ovf_m !== m_ovf || fe_m !== m_fe || ovf_l !== m_ovf || fe_l !== m_fe) begin
                n_fail++;
                $display("FAIL rand_flags @%0d: got om=%b fm=%b ol=%b fl=%b expected o=%b f=%b",
                         cyc, ovf_m, fe_m, ovf_l, fe_l, m_ovf, m_fe);
            end
        end
        reset = 1'b0; cs = 1'b0; clear = 1'b0; rx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_overflow();
        test_framing();
        test_reset_midword();
        test_full_simul();
        test_clear_vs_set();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
